// File: rtl/traffic_pkg.sv
// Shared types for the multi-road traffic light controller.
package traffic_pkg;

   typedef enum logic [1:0] {
      PH_GREEN   = 2'b00,
      PH_YELLOW  = 2'b01,
      PH_ALL_RED = 2'b10,
      PH_FLASH   = 2'b11
   } phase_t;

   // Road index width; a single road still needs one bit.
   function automatic int aw_of(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/tl_lamp_decode.sv
// Combinational lamp decode from registered phase, active road and blink bit.
module tl_lamp_decode
   import traffic_pkg::*;
#(
   parameter int N_ROADS = 3,
   localparam int AW = aw_of(N_ROADS)
) (
   input  phase_t              phase,
   input  logic [AW-1:0]       road,
   input  logic                blink,
   output logic [N_ROADS-1:0]  red,
   output logic [N_ROADS-1:0]  yellow,
   output logic [N_ROADS-1:0]  green
);

   for (genvar gi = 0; gi < N_ROADS; gi++) begin : g_road
      logic sel;
      assign sel        = (road == AW'(gi));
      assign green[gi]  = (phase == PH_GREEN) && sel;
      assign yellow[gi] = ((phase == PH_YELLOW) && sel) || ((phase == PH_FLASH) && blink);
      assign red[gi]    = (phase == PH_ALL_RED) ||
                          (((phase == PH_GREEN) || (phase == PH_YELLOW)) && !sel);
   end

endmodule

// File: rtl/traffic_light_multi.sv
// Round-robin N-road signal controller with pedestrian cut/walk and flash override.
module traffic_light_multi
   import traffic_pkg::*;
#(
   parameter int N_ROADS      = 3,
   parameter int GREEN_TIME   = 90,
   parameter int YELLOW_TIME  = 5,
   parameter int ALL_RED_TIME = 2,
   parameter int PED_CUT      = 10,
   parameter int WALK_TIME    = 8,
   parameter int CW           = 8,
   localparam int AW = aw_of(N_ROADS)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [N_ROADS-1:0]  ped_req,
   input  logic                flash_mode,
   output logic [N_ROADS-1:0]  red,
   output logic [N_ROADS-1:0]  yellow,
   output logic [N_ROADS-1:0]  green,
   output logic [N_ROADS-1:0]  walk,
   output logic [N_ROADS-1:0]  ped_pending,
   output logic [1:0]          phase,
   output logic [AW-1:0]       active_road,
   output logic [CW-1:0]       countdown
);

   localparam logic [CW-1:0] GREEN_LD   = CW'(GREEN_TIME);
   localparam logic [CW-1:0] YELLOW_LD  = CW'(YELLOW_TIME);
   localparam logic [CW-1:0] ALL_RED_LD = CW'(ALL_RED_TIME);
   localparam logic [CW-1:0] CUT_LD     = CW'(PED_CUT);
   localparam logic [CW-1:0] WALK_LD    = CW'(WALK_TIME);
   localparam logic [CW-1:0] ONE        = CW'(1);
   localparam logic [AW-1:0] LAST_ROAD  = AW'(N_ROADS - 1);

   phase_t               phase_q, phase_d;
   logic [AW-1:0]        road_q, road_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [N_ROADS-1:0]   pend_q, pend_d;
   logic [CW-1:0]        walk_cnt_q, walk_cnt_d;
   logic [AW-1:0]        walk_idx_q, walk_idx_d;
   logic                 blink_q, blink_d;
   logic [N_ROADS-1:0]   clr;
   logic                 cut_req;

   always_comb begin
      phase_d    = phase_q;
      road_d     = road_q;
      cnt_d      = cnt_q - ONE;
      blink_d    = blink_q;
      walk_idx_d = walk_idx_q;
      walk_cnt_d = (walk_cnt_q != '0) ? walk_cnt_q - ONE : '0;
      clr        = '0;
      cut_req    = pend_q[road_q] | ped_req[road_q];

      unique case (phase_q)
         PH_GREEN: begin
            if (cnt_q == ONE) begin
               phase_d = PH_YELLOW;
               cnt_d   = YELLOW_LD;
            end else if (cut_req && (cnt_q > CUT_LD)) begin
               cnt_d = CUT_LD;
            end
         end
         PH_YELLOW: begin
            if (cnt_q == ONE) begin
               phase_d = PH_ALL_RED;
               cnt_d   = ALL_RED_LD;
               // Walk starts together with the clearance interval.
               if (pend_q[road_q]) begin
                  clr[road_q] = 1'b1;
                  walk_cnt_d  = WALK_LD;
                  walk_idx_d  = road_q;
               end
            end
         end
         PH_ALL_RED: begin
            if (cnt_q == ONE) begin
               phase_d = PH_GREEN;
               cnt_d   = GREEN_LD;
               road_d  = (road_q == LAST_ROAD) ? '0 : road_q + AW'(1);
            end
         end
         PH_FLASH: begin
            cnt_d   = '0;
            blink_d = ~blink_q;
            if (!flash_mode) begin
               phase_d = PH_ALL_RED;
               cnt_d   = ALL_RED_LD;
            end
         end
         default: ;
      endcase

      pend_d = (pend_q & ~clr) | ped_req;
      if (phase_q == PH_FLASH) begin
         pend_d = '0;
      end

      // Override wins over every timer transition and cut.
      if (flash_mode) begin
         phase_d    = PH_FLASH;
         cnt_d      = '0;
         road_d     = LAST_ROAD;
         walk_cnt_d = '0;
         pend_d     = '0;
         blink_d    = (phase_q == PH_FLASH) ? ~blink_q : 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q    <= PH_GREEN;
         road_q     <= '0;
         cnt_q      <= GREEN_LD;
         pend_q     <= '0;
         walk_cnt_q <= '0;
         walk_idx_q <= '0;
         blink_q    <= 1'b0;
      end else begin
         phase_q    <= phase_d;
         road_q     <= road_d;
         cnt_q      <= cnt_d;
         pend_q     <= pend_d;
         walk_cnt_q <= walk_cnt_d;
         walk_idx_q <= walk_idx_d;
         blink_q    <= blink_d;
      end
   end

   for (genvar gi = 0; gi < N_ROADS; gi++) begin : g_walk
      assign walk[gi] = (walk_cnt_q != '0) && (walk_idx_q == AW'(gi));
   end

   assign phase       = phase_q;
   assign active_road = road_q;
   assign countdown   = cnt_q;
   assign ped_pending = pend_q;

   tl_lamp_decode #(
      .N_ROADS (N_ROADS)
   ) u_lamp (
      .phase  (phase_q),
      .road   (road_q),
      .blink  (blink_q),
      .red    (red),
      .yellow (yellow),
      .green  (green)
   );

endmodule

// File: tb/tb_traffic_light_multi.sv
// Directed table-driven bench for traffic_light_multi at default parameters.
module tb_traffic_light_multi;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [2:0] ped_req;
   logic       flash_mode;
   logic [2:0] red, yellow, green, walk, ped_pending;
   logic [1:0] phase;
   logic [1:0] active_road;
   logic [7:0] countdown;

   int n_total = 0;
   int n_pass  = 0;

   localparam logic [1:0] G = 2'b00, Y = 2'b01, R = 2'b10, F = 2'b11;

   typedef struct {
      int         n;
      logic [2:0] ped;
      logic [1:0] ph;
      int         road;
      int         cnt;
      logic [2:0] pend;
      logic [2:0] wk;
   } vec_t;

   vec_t vq[$];

   always #5 clk = ~clk;

   traffic_light_multi dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .ped_req     (ped_req),
      .flash_mode  (flash_mode),
      .red         (red),
      .yellow      (yellow),
      .green       (green),
      .walk        (walk),
      .ped_pending (ped_pending),
      .phase       (phase),
      .active_road (active_road),
      .countdown   (countdown)
   );

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_state(input string tag, input logic [1:0] ph, input int road,
                              input int cnt, input logic [2:0] pend, input logic [2:0] wk,
                              input logic blink);
      logic [2:0] eg, ey, er;
      for (int i = 0; i < 3; i++) begin
         eg[i] = (ph == G) && (road == i);
         ey[i] = ((ph == Y) && (road == i)) || ((ph == F) && blink);
         er[i] = (ph == R) || ((ph[1] == 1'b0) && (road != i));
      end
      $display("%s: phase=%0d road=%0d cnt=%0d pend=%b walk=%b g=%b y=%b r=%b",
               tag, phase, active_road, countdown, ped_pending, walk, green, yellow, red);
      chk({tag, " phase"},  int'(phase),       int'(ph));
      chk({tag, " road"},   int'(active_road), road);
      chk({tag, " cnt"},    int'(countdown),   cnt);
      chk({tag, " pend"},   int'(ped_pending), int'(pend));
      chk({tag, " walk"},   int'(walk),        int'(wk));
      chk({tag, " green"},  int'(green),       int'(eg));
      chk({tag, " yellow"}, int'(yellow),      int'(ey));
      chk({tag, " red"},    int'(red),         int'(er));
   endtask

   task automatic add(input int n, input logic [2:0] ped, input logic [1:0] ph, input int road,
                      input int cnt, input logic [2:0] pend, input logic [2:0] wk);
      vq.push_back('{n, ped, ph, road, cnt, pend, wk});
   endtask

   initial begin
      rst_n      = 1'b0;
      ped_req    = '0;
      flash_mode = 1'b0;

      // Free-running cycle, then a cut on road0 with its walk.
      add(0,  3'b000, G, 0, 90, 3'b000, 3'b000);
      add(89, 3'b000, G, 0, 1,  3'b000, 3'b000);
      add(1,  3'b000, Y, 0, 5,  3'b000, 3'b000);
      add(4,  3'b000, Y, 0, 1,  3'b000, 3'b000);
      add(1,  3'b000, R, 0, 2,  3'b000, 3'b000);
      add(1,  3'b000, R, 0, 1,  3'b000, 3'b000);
      add(1,  3'b000, G, 1, 90, 3'b000, 3'b000);
      add(97, 3'b000, G, 2, 90, 3'b000, 3'b000);
      add(97, 3'b000, G, 0, 90, 3'b000, 3'b000);
      add(30, 3'b000, G, 0, 60, 3'b000, 3'b000);
      add(1,  3'b001, G, 0, 10, 3'b001, 3'b000);
      add(3,  3'b001, G, 0, 7,  3'b001, 3'b000);
      add(6,  3'b000, G, 0, 1,  3'b001, 3'b000);
      add(1,  3'b000, Y, 0, 5,  3'b001, 3'b000);
      add(5,  3'b000, R, 0, 2,  3'b000, 3'b001);
      add(7,  3'b000, G, 1, 85, 3'b000, 3'b001);
      add(1,  3'b000, G, 1, 84, 3'b000, 3'b000);
      add(91, 3'b000, G, 2, 90, 3'b000, 3'b000);
      // Repeated presses on road2 give a single cut.
      add(10, 3'b000, G, 2, 80, 3'b000, 3'b000);
      add(1,  3'b100, G, 2, 10, 3'b100, 3'b000);
      add(1,  3'b000, G, 2, 9,  3'b100, 3'b000);
      add(1,  3'b100, G, 2, 8,  3'b100, 3'b000);
      add(1,  3'b000, G, 2, 7,  3'b100, 3'b000);
      add(1,  3'b100, G, 2, 6,  3'b100, 3'b000);
      add(1,  3'b000, G, 2, 5,  3'b100, 3'b000);
      add(1,  3'b100, G, 2, 4,  3'b100, 3'b000);
      add(1,  3'b000, G, 2, 3,  3'b100, 3'b000);
      add(1,  3'b100, G, 2, 2,  3'b100, 3'b000);
      add(1,  3'b000, G, 2, 1,  3'b100, 3'b000);
      add(1,  3'b000, Y, 2, 5,  3'b100, 3'b000);
      add(5,  3'b000, R, 2, 2,  3'b000, 3'b100);
      add(2,  3'b000, G, 0, 90, 3'b000, 3'b100);
      add(40, 3'b000, G, 0, 50, 3'b000, 3'b000);
      // Non-active request stays latched; late press on road0 does not cut.
      add(1,  3'b010, G, 0, 49, 3'b010, 3'b000);
      add(42, 3'b000, G, 0, 7,  3'b010, 3'b000);
      add(1,  3'b001, G, 0, 6,  3'b011, 3'b000);
      add(5,  3'b000, G, 0, 1,  3'b011, 3'b000);
      add(1,  3'b000, Y, 0, 5,  3'b011, 3'b000);
      add(5,  3'b000, R, 0, 2,  3'b010, 3'b001);
      add(2,  3'b000, G, 1, 90, 3'b010, 3'b001);
      add(1,  3'b000, G, 1, 10, 3'b010, 3'b001);
      add(9,  3'b000, G, 1, 1,  3'b010, 3'b000);
      add(1,  3'b000, Y, 1, 5,  3'b010, 3'b000);
      add(5,  3'b000, R, 1, 2,  3'b000, 3'b010);
      add(2,  3'b000, G, 2, 90, 3'b000, 3'b010);

      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      for (int k = 0; k < vq.size(); k++) begin
         ped_req = vq[k].ped;
         step(vq[k].n);
         check_state($sformatf("vec%0d", k), vq[k].ph, vq[k].road, vq[k].cnt,
                     vq[k].pend, vq[k].wk, 1'b0);
      end
      ped_req = '0;

      // Mid-operation reset during road1 yellow with requests latched.
      rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      check_state("rst0", G, 0, 90, 3'b000, 3'b000, 1'b0);
      ped_req = 3'b100;
      step(1);
      ped_req = 3'b000;
      step(96);
      check_state("rst_r1g", G, 1, 90, 3'b100, 3'b000, 1'b0);
      ped_req = 3'b001;
      step(1);
      ped_req = 3'b000;
      step(89);
      check_state("rst_r1y", Y, 1, 5, 3'b101, 3'b000, 1'b0);
      step(2);
      #2 rst_n = 1'b0;
      #1 check_state("rst_async", G, 0, 90, 3'b000, 3'b000, 1'b0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      check_state("rst_held", G, 0, 90, 3'b000, 3'b000, 1'b0);
      step(1);
      check_state("rst_run", G, 0, 89, 3'b000, 3'b000, 1'b0);

      // Flash override mid road1 green, with requests that must be ignored.
      step(96);
      step(3);
      check_state("fl_pre", G, 1, 87, 3'b000, 3'b000, 1'b0);
      flash_mode = 1'b1;
      ped_req    = 3'b010;
      for (int k = 0; k < 6; k++) begin
         step(1);
         check_state($sformatf("flash%0d", k), F, 2, 0, 3'b000, 3'b000, (k % 2) == 0);
      end
      flash_mode = 1'b0;
      ped_req    = 3'b000;
      step(1);
      check_state("fl_rel0", R, 2, 2, 3'b000, 3'b000, 1'b0);
      step(1);
      check_state("fl_rel1", R, 2, 1, 3'b000, 3'b000, 1'b0);
      step(1);
      check_state("fl_green", G, 0, 90, 3'b000, 3'b000, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/traffic_light_multi.md
Name: traffic_light_multi

Overview:
Parametrised successor to the two-road traffic_light_system. It drives N_ROADS approaches in round-robin order, with a GREEN -> YELLOW -> ALL_RED sequence per road. Per-road pedestrian requests shorten the active green and earn a timed walk signal. A flash override puts every approach on blinking yellow. One instance sits at the top of the intersection controller, clocked by the 1 s tick.

Parameters:
N_ROADS, 3, number of approaches (2..8)
GREEN_TIME, 90, green duration in cycles
YELLOW_TIME, 5, yellow duration in cycles
ALL_RED_TIME, 2, clearance duration in cycles
PED_CUT, 10, remaining green after a pedestrian cut (1 <= PED_CUT < GREEN_TIME)
WALK_TIME, 8, walk pulse length (WALK_TIME <= ALL_RED_TIME + PED_CUT)
CW, 8, countdown width (must hold GREEN_TIME)

Ports:
clk  in  1  system clock (1 s tick)
rst_n  in  1  asynchronous active-low reset
ped_req  in  N_ROADS  pedestrian button per road, level or pulse
flash_mode  in  1  override: all approaches blink yellow
red  out  N_ROADS  red lamp per road
yellow  out  N_ROADS  yellow lamp per road
green  out  N_ROADS  green lamp per road
walk  out  N_ROADS  pedestrian walk lamp per road
ped_pending  out  N_ROADS  latched, unserved requests
phase  out  2  00 GREEN, 01 YELLOW, 10 ALL_RED, 11 FLASH
active_road  out  AW  road owning the current phase; AW = max(1, clog2(N_ROADS))
countdown  out  CW  cycles remaining in the current phase, including the current cycle

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - phase=GREEN, active_road=0, countdown=GREEN_TIME.
  - green=1, red=all roads except bit0, yellow=0, walk=0, ped_pending=0.
- Phase loads and transitions:
  - Each phase loads its *_TIME on entry; countdown decrements each cycle.
  - On a cycle with countdown==1 the next phase is entered at the next edge, so every phase lasts exactly its loaded count.
  - Order: GREEN(a) -> YELLOW(a) -> ALL_RED(a) -> GREEN((a+1) mod N_ROADS).
  - active_road updates only on the ALL_RED->GREEN edge.
- Lamps are a pure decode of registered phase and active_road:
  - GREEN: green[a]=1, other roads red.
  - YELLOW: yellow[a]=1, other roads red.
  - ALL_RED: all roads red.
  - FLASH: red=green=0, yellow=all equal to blink bit.
- Pedestrian latch:
  - ped_pending[i] is set by ped_req[i] at the next edge.
  - Set wins over a same-cycle clear.
- Pedestrian cut:
  - Applies in GREEN when (ped_pending[a] | ped_req[a]) and countdown > PED_CUT.
  - At the next edge countdown loads PED_CUT instead of decrementing.
  - Repeated presses cannot cut again, since countdown is then <= PED_CUT.
  - A press at countdown <= PED_CUT does not cut.
- Walk:
  - On the YELLOW->ALL_RED edge, if ped_pending[a] is set: clear it, assert walk[a] for exactly WALK_TIME cycles, starting in the first ALL_RED cycle.
  - There is a single walk counter plus a walk index. The parameter constraint guarantees no overlap with the next walk.
- Requests for non-active roads stay latched until their own green arrives.
- Flash mode:
  - flash_mode=1 in any phase: at the next edge phase=FLASH, blink=1, countdown=0, active_road=N_ROADS-1, walk=0, ped_pending=0.
  - blink toggles every cycle while in FLASH.
  - Requests received during FLASH are ignored.
- Flash release: the first cycle with flash_mode=0 enters ALL_RED (countdown=ALL_RED_TIME), then GREEN on road 0.
- Flash priority: flash_mode outranks every timer transition and every cut.
- Mid-operation reset: immediate return to the reset state; all pending and walk state is discarded.

Decomposition:
- Package traffic_pkg holds:
  - phase_t enum (PH_GREEN, PH_YELLOW, PH_ALL_RED, PH_FLASH) with the 2-bit encodings listed in Ports.
  - A localparam helper for AW.
- One natural sub-module, tl_lamp_decode: combinational phase/active_road/blink -> red/yellow/green vectors, parametrised by N_ROADS.
- FSM, timers and the pedestrian logic stay in traffic_light_multi.

Test Plan:
All scenarios use default parameters.
1. Release reset, no requests:
   - Road0 green cycles 0-89, yellow 90-94, all-red 95-96.
   - green[1] at cycle 97; road0 green again at cycle 291.
2. ped_req[0] 4-cycle pulse while road0 green, countdown=60:
   - Next cycle countdown=10, then yellow 10 cycles later.
   - walk[0]=1 for 8 cycles from the first ALL_RED cycle; ped_pending[0] returns to 0.
3. ped_req[1] pulse during road0 green, countdown=50:
   - Road0 runs its full 90 cycles; ped_pending[1]=1.
   - Road1 green enters with countdown 90, next cycle shows 10: 11 green cycles total.
4. ped_req[2] pressed 5 times during road2 green starting at countdown=80:
   - Single cut to 10; no further reload.
   - ped_req[0] at road0 countdown=7: no cut, walk[0] still served at road0 yellow exit.
5. flash_mode high mid-road1 green for 6 cycles:
   - Yellow vector alternates all-ones/zero starting 1; red=green=0; phase=11.
   - On release: 2 cycles all-red, then road0 green with countdown 90.
6. rst_n low for 1 cycle during road1 yellow with ped_pending=3'b101:
   - Outputs return to the reset values immediately.
   - ped_pending=0, walk=0; the sequence restarts at road0.
